// File: rtl/timer_pkg.sv
// Shared register map, field positions and helpers for the multi-channel timer register block.
package timer_pkg;

  localparam int unsigned OFF_TCR   = 32'h00;
  localparam int unsigned OFF_TDR0  = 32'h04;
  localparam int unsigned OFF_TDR1  = 32'h08;
  localparam int unsigned OFF_TIER  = 32'h0C;
  localparam int unsigned OFF_TISR  = 32'h10;
  localparam int unsigned OFF_THCSR = 32'h14;

  localparam int unsigned CH_BASE   = 32'h20;
  localparam int unsigned CH_STRIDE = 32'h10;

  localparam int unsigned TCR_TIMER_EN = 0;
  localparam int unsigned TCR_DIV_EN   = 1;
  localparam int unsigned TCR_DIV_LSB  = 8;
  localparam int unsigned DIV_W        = 4;
  localparam int unsigned DIV_MAX      = 8;
  localparam int unsigned DIV_RST      = 1;

  localparam int unsigned CMCR_CH_EN    = 0;
  localparam int unsigned CMCR_PERIODIC = 1;

  typedef enum logic [1:0] {
    CH_CMP_LO = 2'd0,
    CH_CMP_HI = 2'd1,
    CH_PER    = 2'd2,
    CH_CMCR   = 2'd3
  } ch_reg_e;

  typedef struct packed {
    logic [19:0]      rsvd_hi;
    logic [DIV_W-1:0] div_val;
    logic [5:0]       rsvd_lo;
    logic             div_en;
    logic             timer_en;
  } tcr_t;

  // Byte-granular merge of write data into an existing word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_cmp_ch.sv
// One compare channel: compare value, period, mode, edge detector and periodic reload.
module timer_cmp_ch
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [31:0]      wdata,
  input  logic [3:0]       pstrb,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic             wr_per,
  input  logic             wr_cmcr,
  output logic [CNT_W-1:0] cmp,
  output logic [31:0]      per,
  output logic             ch_en,
  output logic             periodic,
  output logic             evt_c
);

  localparam int unsigned HW = CNT_W - 32;

  logic             match_c;
  logic             match_q;
  logic             en_clr_c;
  logic [CNT_W-1:0] cmp_base;
  logic [CNT_W-1:0] cmp_nxt;
  logic [31:0]      lo_m;
  logic [31:0]      hi_m;

  // Reload sum forms the base; strobed APB bytes then override it.
  always_comb begin
    match_c  = ch_en && (cnt == cmp);
    evt_c    = match_c && !match_q;
    en_clr_c = wr_cmcr && pstrb[0] && !wdata[CMCR_CH_EN];
    cmp_base = (evt_c && periodic) ? cmp + CNT_W'(per) : cmp;
    lo_m     = strb_merge(cmp_base[31:0], wdata, pstrb);
    hi_m     = strb_merge(32'(cmp_base[CNT_W-1:32]), wdata, pstrb);
    cmp_nxt  = cmp_base;
    if (wr_lo) cmp_nxt[31:0]       = lo_m;
    if (wr_hi) cmp_nxt[CNT_W-1:32] = hi_m[HW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp      <= '1;
      per      <= '0;
      ch_en    <= 1'b0;
      periodic <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      cmp     <= cmp_nxt;
      match_q <= en_clr_c ? 1'b0 : match_c;
      if (wr_per) per <= strb_merge(per, wdata, pstrb);
      if (wr_cmcr && pstrb[0]) begin
        ch_en    <= wdata[CMCR_CH_EN];
        periodic <= wdata[CMCR_PERIODIC];
      end
    end
  end

endmodule

// File: rtl/timer_mch_regs.sv
// APB register file for the multi-channel timer: decode, global registers, read mux and error logic.
// Optional TIMER_SNAPSHOT_EN: a TDR0 read latches the counter upper word for a coherent TDR1 read.
module timer_mch_regs
  import timer_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       rdata,
  output logic              pslverr,
  input  logic [CNT_W-1:0]  cnt,
  output logic              timer_en,
  output logic              div_en,
  output logic [3:0]        div_val,
  output logic              halt_reg,
  input  logic              halt_ack,
  output logic [1:0]        tdr_wr_sel,
  output logic [31:0]       wdata_cnt,
  output logic [NCH-1:0]    int_vec,
  output logic              tim_int
);

  localparam int unsigned HW = CNT_W - 32;

  logic hit_tcr, hit_tdr0, hit_tdr1, hit_tier, hit_tisr, hit_thcsr, hit_ch;
  logic map_ok, tcr_bad, wr_ok;
  logic [ADDR_W-1:0] ch_off, ch_idx;
  ch_reg_e           ch_reg;
  logic [1:0]        new_en;
  logic [DIV_W-1:0]  new_div;
  logic [NCH-1:0]    tier, tisr, tisr_clr, ch_wr, evt_v, ch_en_v, periodic_v;
  logic [CNT_W-1:0]  cmp_v [NCH];
  logic [31:0]       per_v [NCH];
  logic [CNT_W-1:0]  sel_cmp;
  logic [31:0]       sel_per;
  logic              sel_en, sel_pd;
  logic [HW-1:0]     cnt_hi;
  tcr_t              tcr_rd;

  // Address decode and access error checks.
  always_comb begin
    hit_tcr   = addr == ADDR_W'(OFF_TCR);
    hit_tdr0  = addr == ADDR_W'(OFF_TDR0);
    hit_tdr1  = addr == ADDR_W'(OFF_TDR1);
    hit_tier  = addr == ADDR_W'(OFF_TIER);
    hit_tisr  = addr == ADDR_W'(OFF_TISR);
    hit_thcsr = addr == ADDR_W'(OFF_THCSR);
    ch_off    = addr - ADDR_W'(CH_BASE);
    ch_idx    = ch_off / ADDR_W'(CH_STRIDE);
    ch_reg    = ch_reg_e'(ch_off[3:2]);
    hit_ch    = (addr >= ADDR_W'(CH_BASE)) && (ch_idx < ADDR_W'(NCH)) && (addr[1:0] == 2'b00);
    map_ok    = hit_tcr || hit_tdr0 || hit_tdr1 || hit_tier || hit_tisr || hit_thcsr || hit_ch;
    new_en    = pstrb[0] ? {wdata[TCR_DIV_EN], wdata[TCR_TIMER_EN]} : {div_en, timer_en};
    new_div   = pstrb[1] ? wdata[TCR_DIV_LSB +: DIV_W] : div_val;
    tcr_bad   = wr_en && hit_tcr &&
                ((new_div > DIV_W'(DIV_MAX)) ||
                 (timer_en && ((new_div != div_val) || (new_en[1] != div_en))));
    pslverr   = (wr_en || rd_en) && (!map_ok || tcr_bad);
    wr_ok     = wr_en && map_ok && !tcr_bad;
    tisr_clr  = (wr_ok && hit_tisr && pstrb[0]) ? wdata[NCH-1:0] : '0;
    ch_wr     = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      ch_wr[i] = wr_ok && hit_ch && (ch_idx == ADDR_W'(i));
    end
  end

  assign tdr_wr_sel = {wr_ok && hit_tdr1, wr_ok && hit_tdr0};
  assign wdata_cnt  = wdata;

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    timer_cmp_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .cnt      (cnt),
      .wdata    (wdata),
      .pstrb    (pstrb),
      .wr_lo    (ch_wr[i] && (ch_reg == CH_CMP_LO)),
      .wr_hi    (ch_wr[i] && (ch_reg == CH_CMP_HI)),
      .wr_per   (ch_wr[i] && (ch_reg == CH_PER)),
      .wr_cmcr  (ch_wr[i] && (ch_reg == CH_CMCR)),
      .cmp      (cmp_v[i]),
      .per      (per_v[i]),
      .ch_en    (ch_en_v[i]),
      .periodic (periodic_v[i]),
      .evt_c    (evt_v[i])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= DIV_W'(DIV_RST);
      halt_reg <= 1'b0;
      tier     <= '0;
      tisr     <= '0;
      int_vec  <= '0;
      tim_int  <= 1'b0;
    end else begin
      if (wr_ok && hit_tcr) begin
        timer_en <= new_en[0];
        div_en   <= new_en[1];
        div_val  <= new_div;
      end
      if (wr_ok && hit_tier && pstrb[0])  tier     <= wdata[NCH-1:0];
      if (wr_ok && hit_thcsr && pstrb[0]) halt_reg <= wdata[0];
      // A new event outranks a simultaneous W1C of the same bit.
      tisr    <= (tisr & ~tisr_clr) | evt_v;
      int_vec <= tisr & tier;
      tim_int <= |(tisr & tier);
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)             cnt_hi <= '0;
    else if (rd_en && hit_tdr0) cnt_hi <= cnt[CNT_W-1:32];
  end
`else
  assign cnt_hi = cnt[CNT_W-1:32];
`endif

  // Read mux; unmapped or idle reads return zero.
  always_comb begin
    sel_cmp = '0;
    sel_per = '0;
    sel_en  = 1'b0;
    sel_pd  = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_idx == ADDR_W'(i)) begin
        sel_cmp = cmp_v[i];
        sel_per = per_v[i];
        sel_en  = ch_en_v[i];
        sel_pd  = periodic_v[i];
      end
    end
    tcr_rd = '{rsvd_hi: '0, div_val: div_val, rsvd_lo: '0, div_en: div_en, timer_en: timer_en};
    rdata  = '0;
    if (rd_en && map_ok) begin
      if (hit_tcr)        rdata = tcr_rd;
      else if (hit_tdr0)  rdata = cnt[31:0];
      else if (hit_tdr1)  rdata = 32'(cnt_hi);
      else if (hit_tier)  rdata = 32'(tier);
      else if (hit_tisr)  rdata = 32'(tisr);
      else if (hit_thcsr) rdata = {30'b0, halt_ack, halt_reg};
      else begin
        case (ch_reg)
          CH_CMP_LO: rdata = sel_cmp[31:0];
          CH_CMP_HI: rdata = 32'(sel_cmp[CNT_W-1:32]);
          CH_PER:    rdata = sel_per;
          CH_CMCR:   rdata = {30'b0, sel_pd, sel_en};
          default:   rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_mch_regs.sv
// Bench for timer_mch_regs: register-level reference model checked every cycle plus directed literal checks.
module tb_timer_mch_regs;

  localparam int unsigned NCH    = 4;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned ADDR_W = 12;

  logic              sys_clk, sys_rst_n, wr_en, rd_en, halt_ack;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, rdata, wdata_cnt;
  logic [3:0]        pstrb, div_val;
  logic              pslverr, timer_en, div_en, halt_reg, tim_int;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        tdr_wr_sel;
  logic [NCH-1:0]    int_vec;

  timer_mch_regs #(.NCH(NCH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .pstrb(pstrb), .rdata(rdata), .pslverr(pslverr),
    .cnt(cnt), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
    .halt_reg(halt_reg), .halt_ack(halt_ack), .tdr_wr_sel(tdr_wr_sel),
    .wdata_cnt(wdata_cnt), .int_vec(int_vec), .tim_int(tim_int)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents.
  logic [63:0]    m_cmp [NCH];
  logic [31:0]    m_per [NCH];
  bit             m_en [NCH], m_pd [NCH], m_prev [NCH];
  int             m_evcnt [NCH];
  bit [NCH-1:0]   m_tier, m_tisr, m_int;
  bit             m_ten, m_den, m_halt;
  bit [3:0]       m_div;
  logic [31:0]    m_shadow;

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cmp[i] = '1; m_per[i] = '0; m_en[i] = 0; m_pd[i] = 0; m_prev[i] = 0; m_evcnt[i] = 0;
    end
    m_tier = '0; m_tisr = '0; m_int = '0;
    m_ten = 0; m_den = 0; m_halt = 0; m_div = 4'd1; m_shadow = '0;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // 0 unmapped, 1 TCR, 2 TDR0, 3 TDR1, 4 TIER, 5 TISR, 6 THCSR, 7 channel register
  function automatic int kind_of(input logic [ADDR_W-1:0] a, output int ch, output int r);
    int v;
    v = int'(a); ch = 0; r = 0;
    case (v)
      0: return 1;  4: return 2;  8: return 3;
      12: return 4; 16: return 5; 20: return 6;
      default: ;
    endcase
    if (v >= 32 && v % 4 == 0 && (v - 32) / 16 < NCH) begin
      ch = (v - 32) / 16; r = (v % 16) / 4;
      return 7;
    end
    return 0;
  endfunction

  function automatic bit m_err();
    int k, ch, r;
    bit [3:0] nd;
    bit       ne;
    k = kind_of(addr, ch, r);
    if (!(wr_en || rd_en)) return 0;
    if (k == 0) return 1;
    if (wr_en && k == 1) begin
      nd = pstrb[1] ? wdata[11:8] : m_div;
      ne = pstrb[0] ? wdata[1] : m_den;
      if (nd > 8) return 1;
      if (m_ten && (nd != m_div || ne != m_den)) return 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read();
    int k, ch, r;
    k = kind_of(addr, ch, r);
    if (!rd_en || m_err()) return 0;
    case (k)
      1: return {20'h0, m_div, 6'h0, m_den, m_ten};
      2: return cnt[31:0];
`ifdef TIMER_SNAPSHOT_EN
      3: return m_shadow;
`else
      3: return cnt[63:32];
`endif
      4: return 32'(m_tier);
      5: return 32'(m_tisr);
      6: return {30'h0, halt_ack, m_halt};
      7: case (r)
           0: return m_cmp[ch][31:0];
           1: return m_cmp[ch][63:32];
           2: return m_per[ch];
           default: return {30'h0, m_pd[ch], m_en[ch]};
         endcase
      default: return 0;
    endcase
  endfunction

  function automatic void m_step();
    int k, ch, r;
    bit wok;
    bit mt [NCH];
    bit [NCH-1:0] ev, clr;
    k   = kind_of(addr, ch, r);
    wok = wr_en && !m_err();
    for (int i = 0; i < NCH; i++) begin
      mt[i] = m_en[i] && (cnt == m_cmp[i]);
      ev[i] = mt[i] && !m_prev[i];
      if (ev[i]) m_evcnt[i]++;
    end
    m_int = m_tisr & m_tier;
    if (rd_en && k == 2) m_shadow = cnt[63:32];
    for (int i = 0; i < NCH; i++) begin
      if (ev[i] && m_pd[i]) m_cmp[i] = m_cmp[i] + 64'(m_per[i]);
      m_prev[i] = mt[i];
    end
    clr = '0;
    if (wok) begin
      case (k)
        1: begin
             if (pstrb[0]) begin m_ten = wdata[0]; m_den = wdata[1]; end
             if (pstrb[1]) m_div = wdata[11:8];
           end
        4: if (pstrb[0]) m_tier = wdata[NCH-1:0];
        5: if (pstrb[0]) clr = wdata[NCH-1:0];
        6: if (pstrb[0]) m_halt = wdata[0];
        7: case (r)
             0: m_cmp[ch][31:0]  = bmerge(m_cmp[ch][31:0], wdata, pstrb);
             1: m_cmp[ch][63:32] = bmerge(m_cmp[ch][63:32], wdata, pstrb);
             2: m_per[ch]        = bmerge(m_per[ch], wdata, pstrb);
             default: if (pstrb[0]) begin
                        m_en[ch] = wdata[0]; m_pd[ch] = wdata[1];
                        if (!m_en[ch]) m_prev[ch] = 0;
                      end
           endcase
        default: ;
      endcase
    end
    m_tisr = (m_tisr & ~clr) | ev;
  endfunction

  always @(negedge sys_rst_n) m_reset();
  always @(posedge sys_clk) if (sys_rst_n) m_step();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge sys_clk) begin
    int k, ch, r;
    bit ok;
    k  = kind_of(addr, ch, r);
    ok = wr_en && !m_err();
    chk("int_vec", int_vec, m_int);
    chk("tim_int", tim_int, |m_int);
    chk("tcr_out", {div_val, div_en, timer_en}, {m_div, m_den, m_ten});
    chk("halt_reg", halt_reg, m_halt);
    chk("tdr_wr_sel", tdr_wr_sel, {ok && k == 3, ok && k == 2});
    chk("wdata_cnt", wdata_cnt, wdata);
    chk("pslverr", pslverr, m_err());
    chk("rdata", rdata, m_read());
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s, input int exp_err = -1);
    wr_en = 1; addr = a; wdata = d; pstrb = s;
    @(negedge sys_clk);
    if (exp_err >= 0) chk($sformatf("wr_err@%0h", a), pslverr, exp_err);
    tick();
    wr_en = 0; pstrb = 0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input int exp_err = -1);
    rd_en = 1; addr = a;
    @(negedge sys_clk);
    chk($sformatf("rd@%0h", a), rdata, exp);
    if (exp_err >= 0) chk($sformatf("rd_err@%0h", a), pslverr, exp_err);
    tick();
    rd_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    m_reset();
    sys_rst_n = 0; wr_en = 0; rd_en = 0; addr = '0; wdata = '0; pstrb = '0;
    cnt = '0; halt_ack = 0;
    repeat (2) tick();
    sys_rst_n = 1;
    tick();

    // Reset values
    chk("rst_tim_int", tim_int, 0);
    rd(12'h000, 32'h0000_0100);
    rd(12'h020, 32'hFFFF_FFFF);
    rd(12'h024, 32'hFFFF_FFFF);

    // One-shot channel 0, counter stalled on the compare value
    wr(12'h020, 32'd100, 4'hF);
    wr(12'h024, 32'd0, 4'hF);
    wr(12'h02C, 32'h1, 4'hF);
    wr(12'h00C, 32'h1, 4'hF);
    cnt = 99; tick();
    cnt = 100; tick();
    chk("tim_int_before", tim_int, 0);
    rd(12'h010, 32'h1);
    chk("tim_int_after", tim_int, 1);
    wr(12'h010, 32'h1, 4'hF, 0);
    tick();
    chk("tim_int_cleared", tim_int, 0);
    rd(12'h010, 32'h0);
    chk("model_ev0_once", m_evcnt[0], 1);

    // Periodic channel 1
    cnt = 0;
    wr(12'h030, 32'd50, 4'hF);
    wr(12'h034, 32'd0, 4'hF);
    wr(12'h038, 32'd25, 4'hF);
    wr(12'h00C, 32'h3, 4'hF);
    wr(12'h03C, 32'h3, 4'hF);
    for (int v = 40; v <= 105; v++) begin cnt = 64'(v); tick(); end
    chk("model_ev1_count", m_evcnt[1], 3);
    chk("model_cmp1", m_cmp[1], 64'd125);
    rd(12'h030, 32'd125);
    rd(12'h010, 32'h3);

    // Reload colliding with a partial CMP_LO write
    wr(12'h010, 32'hF, 4'hF);
    cnt = 110; tick();
    wr(12'h038, 32'h0102_0304, 4'hF);
    cnt = 125;
    wr(12'h030, 32'h0000_00AA, 4'h1);
    rd(12'h030, 32'h0102_03AA);
    rd(12'h034, 32'h0);

    // Disabling ch_en re-arms the edge detector while stalled on the match
    wr(12'h010, 32'hF, 4'hF);
    cnt = 100; tick();
    wr(12'h010, 32'hF, 4'hF);
    wr(12'h02C, 32'h0, 4'hF);
    wr(12'h02C, 32'h1, 4'hF);
    tick();
    rd(12'h010, 32'h1);

    // TCR rules and unmapped accesses
    wr(12'h000, 32'h0000_0900, 4'hF, 1);
    rd(12'h000, 32'h0000_0100);
    wr(12'h000, 32'h0000_0101, 4'hF, 0);
    wr(12'h000, 32'h0000_0201, 4'hF, 1);
    rd(12'h000, 32'h0000_0101);
    wr(12'h000, 32'h0000_0100, 4'hF, 0);
    wr(12'h000, 32'h0000_0803, 4'hF, 0);
    wr(12'h000, 32'h0000_0001, 4'h1, 1);
    wr(12'h000, 32'h0000_0802, 4'hF, 0);
    rd(12'h000, 32'h0000_0802, 0);
    rd(12'hFFC, 32'h0, 1);
    rd(12'h018, 32'h0, 1);
    wr(12'h060, 32'h1234, 4'hF, 1);
    halt_ack = 1;
    wr(12'h014, 32'h1, 4'hF, 0);
    rd(12'h014, 32'h3, 0);

    // Counter read coherence and TDR write strobes
    cnt = 64'h0000_0001_FFFF_FFFF;
    rd(12'h004, 32'hFFFF_FFFF);
    cnt = 64'h0000_0002_0000_0000;
`ifdef TIMER_SNAPSHOT_EN
    rd(12'h008, 32'h1);
`else
    rd(12'h008, 32'h2);
`endif
    wr(12'h004, 32'h55, 4'hF, 0);
    wr(12'h008, 32'h66, 4'hF, 0);

    // Asynchronous reset mid-operation
    chk("pre_reset_int", int_vec, 4'h1);
    #2 sys_rst_n = 0;
    #1;
    chk("arst_int_vec", int_vec, 0);
    chk("arst_tim_int", tim_int, 0);
    chk("arst_div_val", div_val, 1);
    chk("arst_timer_en", timer_en, 0);
    @(posedge sys_clk); #1 sys_rst_n = 1;
    cnt = 100;
    tick();
    rd(12'h020, 32'hFFFF_FFFF);
    rd(12'h000, 32'h0000_0100);
    rd(12'h010, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
